// File: rtl/addr_count_gen_if.sv
// Control and count bundle between the sweep controller and addr_count_gen.
// Master drives start/pause/stop; slave returns count and status strobes.
interface addr_count_gen_if;
    logic       start;
    logic       pause;
    logic       stop;
    logic [9:0] count;
    logic       running;
    logic       slot_strobe;
    logic       done;

    modport master (
        output start, pause, stop,
        input  count, running, slot_strobe, done
    );

    modport slave (
        input  start, pause, stop,
        output count, running, slot_strobe, done
    );
endinterface

// File: rtl/addr_count_gen.sv
// Purpose: prescaled 0..COUNT_MAX sweep counter with slot strobe and done pulse.
// Latency: all outputs registered, one cycle after the deciding clk edge.
// Backpressure: none; pause freezes the sweep, stop aborts it (ADDR_COUNT_LOOP_EN repeats sweeps).
module addr_count_gen #(
    parameter int CLK_DIV   = 4,
    parameter int COUNT_MAX = 207,
    parameter int SLOT_LEN  = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    addr_count_gen_if.slave  bus
);

    localparam int PW = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
    localparam logic [15:0]   DIV_LAST   = 16'(CLK_DIV - 1);
    localparam logic [9:0]    COUNT_LAST = 10'(COUNT_MAX);
    localparam logic [PW-1:0] PHASE_LAST = PW'(SLOT_LEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [9:0]    count_q, count_d;
    logic [15:0]   div_q, div_d;
    logic [PW-1:0] phase_q, phase_d;
    logic          running_q, running_d;
    logic          strobe_q, strobe_d;
    logic          done_q, done_d;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        div_d    = div_q;
        phase_d  = phase_q;
        strobe_d = 1'b0;
        done_d   = 1'b0;

        if (bus.stop) begin
            state_d = S_IDLE;
            count_d = '0;
            div_d   = '0;
            phase_d = '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    count_d = '0;
                    div_d   = '0;
                    phase_d = '0;
                    if (bus.start) begin
                        // Entering RUN at count 0 is itself a slot-0 boundary.
                        state_d  = S_RUN;
                        strobe_d = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_RUN: begin
                    if (bus.pause) begin
                        state_d = S_HOLD;
                    end else if (div_q == DIV_LAST) begin
                        div_d = '0;
                        if (count_q == COUNT_LAST) begin
                            count_d = '0;
                            phase_d = '0;
                            done_d  = 1'b1;
`ifdef ADDR_COUNT_LOOP_EN
                            strobe_d = 1'b1;
`else
                            state_d = S_DONE;
`endif
                        end else begin
                            count_d = count_q + 10'd1;
                            // phase tracks count mod SLOT_LEN without a divider
                            if (phase_q == PHASE_LAST) begin
                                phase_d  = '0;
                                strobe_d = 1'b1;
                            end else begin
                                phase_d = phase_q + 1'b1;
                            end
                        end
                    end else begin
                        div_d = div_q + 16'd1;
                    end
                end
                S_HOLD: begin
                    if (!bus.pause) begin
                        state_d = S_RUN;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        running_d = (state_d == S_RUN) || (state_d == S_HOLD);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            div_q     <= '0;
            phase_q   <= '0;
            running_q <= 1'b0;
            strobe_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            div_q     <= div_d;
            phase_q   <= phase_d;
            running_q <= running_d;
            strobe_q  <= strobe_d;
            done_q    <= done_d;
        end
    end

    assign bus.count       = count_q;
    assign bus.running     = running_q;
    assign bus.slot_strobe = strobe_q;
    assign bus.done        = done_q;

endmodule
